piso_serializer_ctrl: RTL and testbench

//  Sequencer for the parallel-in serial-out shift register. Accepts parallel words

---
 rtl/piso_serializer_ctrl_pkg.sv | 17 +
 rtl/piso_serializer_ctrl_if.sv | 37 +++
 rtl/piso_serializer_ctrl_shift_reg.sv | 46 ++++
 rtl/piso_serializer_ctrl.sv | 131 +++++++++++++
 tb/tb_piso_serializer_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_serializer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//   Shared types and constants for the PISO serializer controller.
//   - state_e       : controller FSM state encoding (IDLE / SHIFT / GAP)
//   - DEFAULT_WIDTH : default frame width in bits
// ---------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_serializer_ctrl_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_ctrl_if
//   Bundles the word-side handshake and the serial-side handshake of the
//   serializer controller.
//   Word side   : in_data, in_valid (producer -> ctrl), in_ready (ctrl -> producer)
//   Serial side : ser_out, ser_valid, ser_first, ser_last (ctrl -> consumer),
//                 ser_ready (consumer -> ctrl)
//   Status      : busy (frame in flight or inter-frame gap active)
//   Modports    : slave  = controller view, master = producer/consumer view
// ---------------------------------------------------------------------------
interface piso_serializer_ctrl_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

endinterface

// File: rtl/piso_serializer_ctrl_shift_reg.sv
// ---------------------------------------------------------------------------
// piso_shift_reg
//   Parallel-load / shift register feeding the serial output.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (clears contents)
//   en_i     : register updates this edge when 1, holds otherwise
//   sl_bar_i : 0 = load par_i, 1 = shift one position toward the output end
//   par_i    : parallel word to load
//   ser_o    : bit currently at the output end
// ---------------------------------------------------------------------------
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sl_bar_i,
  input  logic [WIDTH-1:0] par_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shifted;

  // The output end is the MSB or LSB; the shift moves the next bit toward it
  // and back-fills zeros.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted = {data_q[WIDTH-2:0], 1'b0};
      assign ser_o   = data_q[WIDTH-1];
    end else begin : g_lsb
      assign shifted = {1'b0, data_q[WIDTH-1:1]};
      assign ser_o   = data_q[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= sl_bar_i ? shifted : par_i;
    end
  end

endmodule

// File: rtl/piso_serializer_ctrl.sv
// ---------------------------------------------------------------------------
// piso_serializer_ctrl
//   Sequencer for a PISO shift register: accepts parallel words on a
//   valid/ready handshake and emits them one bit per serial beat with
//   first/last framing, stall support and an optional inter-frame gap.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : piso_serializer_ctrl_if.slave (in_data/in_valid/in_ready,
//           ser_out/ser_valid/ser_ready/ser_first/ser_last, busy)
// ---------------------------------------------------------------------------
module piso_serializer_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  piso_serializer_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            ready_en_q;   // holds in_ready low while in reset
  logic            in_ready;
  logic            ser_valid;
  logic            busy;
  logic            sr_en;
  logic            sr_sl_bar;
  logic            sr_bit;
  logic            at_last;

  assign at_last = (bit_cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b0;
    sr_en     = 1'b0;
    sr_sl_bar = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = ready_en_q;
        if (bus.in_valid && ready_en_q) begin
          sr_en     = 1'b1;
          sr_sl_bar = 1'b0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        // Next word may be taken on the last-bit beat itself so frames run
        // back to back; a configured gap always forces a return through IDLE.
        in_ready  = (GAP_CYCLES == 0) && bus.ser_ready && at_last;
        if (bus.ser_ready) begin
          if (at_last) begin
            bit_cnt_d = '0;
            if (GAP_CYCLES > 0) begin
              gap_cnt_d = '0;
              state_d   = GAP;
            end else if (bus.in_valid) begin
              sr_en     = 1'b1;
              sr_sl_bar = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sr_en     = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        busy      = 1'b1;
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ready_en_q <= 1'b1;
    end
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (sr_en),
    .sl_bar_i (sr_sl_bar),
    .par_i    (bus.in_data),
    .ser_o    (sr_bit)
  );

  assign bus.in_ready  = in_ready;
  assign bus.ser_valid = ser_valid;
  assign bus.busy      = busy;
  assign bus.ser_out   = ser_valid & sr_bit;
  assign bus.ser_first = ser_valid && (bit_cnt_q == '0);
  assign bus.ser_last  = ser_valid && at_last;

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer_ctrl
//   Two controller instances: A (WIDTH=4, MSB first, no gap) and
//   B (WIDTH=4, LSB first, GAP_CYCLES=2). Inputs are driven on the falling
//   edge and outputs compared 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_piso_serializer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;          // 0 = drive/observe A, 1 = drive/observe B
  logic       drv_valid;
  logic [3:0] drv_data;
  logic       drv_sready;

  piso_serializer_ctrl_if #(.WIDTH(4)) ifa ();
  piso_serializer_ctrl_if #(.WIDTH(4)) ifb ();

  piso_serializer_ctrl #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  piso_serializer_ctrl #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  assign ifa.in_valid  = drv_valid & ~sel;
  assign ifa.in_data   = drv_data;
  assign ifa.ser_ready = drv_sready;
  assign ifb.in_valid  = drv_valid & sel;
  assign ifb.in_data   = drv_data;
  assign ifb.ser_ready = drv_sready;

  logic o_rdy, o_valid, o_out, o_first, o_last, o_busy;
  assign o_rdy   = sel ? ifb.in_ready  : ifa.in_ready;
  assign o_valid = sel ? ifb.ser_valid : ifa.ser_valid;
  assign o_out   = sel ? ifb.ser_out   : ifa.ser_out;
  assign o_first = sel ? ifb.ser_first : ifa.ser_first;
  assign o_last  = sel ? ifb.ser_last  : ifa.ser_last;
  assign o_busy  = sel ? ifb.busy      : ifa.busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  // One whole frame: word in, expected bit stream in send order (bit 3 first)
  typedef struct {
    logic       sel;
    logic [3:0] word;
    logic [3:0] exp_bits;
  } frame_t;

  // One cycle of a hand-written sequence: inputs + expected outputs
  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       sr;
    logic       e_valid, e_out, e_first, e_last, e_rdy, e_busy;
  } step_t;

  frame_t frames [8];
  step_t  stall_seq [16];
  step_t  gap_seq [15];

  task automatic chk(input string name, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic eo,
                         input logic ef, input logic el, input logic er, input logic eb);
    chk({tag, " ser_valid"}, o_valid, ev);
    chk({tag, " ser_out"},   o_out,   eo);
    chk({tag, " ser_first"}, o_first, ef);
    chk({tag, " ser_last"},  o_last,  el);
    chk({tag, " in_ready"},  o_rdy,   er);
    chk({tag, " busy"},      o_busy,  eb);
  endtask

  // Drive inputs on the falling edge, settle, then the caller compares.
  task automatic cyc(input logic v, input logic [3:0] d, input logic sr);
    @(negedge clk);
    drv_valid  = v;
    drv_data   = d;
    drv_sready = sr;
    #1;
  endtask

  task automatic run_steps(input string name, input step_t s);
    cyc(s.v, s.d, s.sr);
    chk_out(name, s.e_valid, s.e_out, s.e_first, s.e_last, s.e_rdy, s.e_busy);
  endtask

  initial begin
    // Frames: A is MSB first, B is LSB first
    frames[0] = '{1'b0, 4'b1011, 4'b1011};
    frames[1] = '{1'b0, 4'b0110, 4'b0110};
    frames[2] = '{1'b0, 4'b1111, 4'b1111};
    frames[3] = '{1'b0, 4'b0000, 4'b0000};
    frames[4] = '{1'b1, 4'b0001, 4'b1000};
    frames[5] = '{1'b1, 4'b1000, 4'b0001};
    frames[6] = '{1'b1, 4'b1101, 4'b1011};
    frames[7] = '{1'b1, 4'b0110, 4'b0110};

    // Stall on A: 1100 with bit 2 held 3 cycles, then stall on the last bit
    // with 1001 waiting, then a stall on bit 0 of 1001.
    //                  v  d     sr   val out fst lst rdy bsy
    stall_seq[0]  = '{1'b1, 4'hC, 1'b1, 0, 0, 0, 0, 1, 0};
    stall_seq[1]  = '{1'b0, 4'h0, 1'b1, 1, 1, 1, 0, 0, 1};
    stall_seq[2]  = '{1'b0, 4'h0, 1'b1, 1, 1, 0, 0, 0, 1};
    stall_seq[3]  = '{1'b0, 4'h0, 1'b0, 1, 0, 0, 0, 0, 1};
    stall_seq[4]  = '{1'b0, 4'h0, 1'b0, 1, 0, 0, 0, 0, 1};
    stall_seq[5]  = '{1'b0, 4'h0, 1'b0, 1, 0, 0, 0, 0, 1};
    stall_seq[6]  = '{1'b0, 4'h0, 1'b1, 1, 0, 0, 0, 0, 1};
    stall_seq[7]  = '{1'b1, 4'h9, 1'b0, 1, 0, 0, 1, 0, 1};
    stall_seq[8]  = '{1'b1, 4'h9, 1'b0, 1, 0, 0, 1, 0, 1};
    stall_seq[9]  = '{1'b1, 4'h9, 1'b1, 1, 0, 0, 1, 1, 1};
    stall_seq[10] = '{1'b0, 4'h0, 1'b0, 1, 1, 1, 0, 0, 1};
    stall_seq[11] = '{1'b0, 4'h0, 1'b1, 1, 1, 1, 0, 0, 1};
    stall_seq[12] = '{1'b0, 4'h0, 1'b1, 1, 0, 0, 0, 0, 1};
    stall_seq[13] = '{1'b0, 4'h0, 1'b1, 1, 0, 0, 0, 0, 1};
    stall_seq[14] = '{1'b0, 4'h0, 1'b1, 1, 1, 0, 1, 1, 1};
    stall_seq[15] = '{1'b0, 4'h0, 1'b1, 0, 0, 0, 0, 1, 0};

    // Gap on B: 0001 then 1000 with in_valid held, 2 gap cycles between
    gap_seq[0]  = '{1'b1, 4'h1, 1'b1, 0, 0, 0, 0, 1, 0};
    gap_seq[1]  = '{1'b1, 4'h8, 1'b1, 1, 1, 1, 0, 0, 1};
    gap_seq[2]  = '{1'b1, 4'h8, 1'b1, 1, 0, 0, 0, 0, 1};
    gap_seq[3]  = '{1'b1, 4'h8, 1'b1, 1, 0, 0, 0, 0, 1};
    gap_seq[4]  = '{1'b1, 4'h8, 1'b1, 1, 0, 0, 1, 0, 1};
    gap_seq[5]  = '{1'b1, 4'h8, 1'b1, 0, 0, 0, 0, 0, 1};
    gap_seq[6]  = '{1'b1, 4'h8, 1'b1, 0, 0, 0, 0, 0, 1};
    gap_seq[7]  = '{1'b1, 4'h8, 1'b1, 0, 0, 0, 0, 1, 0};
    gap_seq[8]  = '{1'b0, 4'h0, 1'b1, 1, 0, 1, 0, 0, 1};
    gap_seq[9]  = '{1'b0, 4'h0, 1'b1, 1, 0, 0, 0, 0, 1};
    gap_seq[10] = '{1'b0, 4'h0, 1'b1, 1, 0, 0, 0, 0, 1};
    gap_seq[11] = '{1'b0, 4'h0, 1'b1, 1, 1, 0, 1, 0, 1};
    gap_seq[12] = '{1'b0, 4'h0, 1'b1, 0, 0, 0, 0, 0, 1};
    gap_seq[13] = '{1'b0, 4'h0, 1'b1, 0, 0, 0, 0, 0, 1};
    gap_seq[14] = '{1'b0, 4'h0, 1'b1, 0, 0, 0, 0, 1, 0};

    // ---------------- reset state ----------------
    sel        = 1'b0;
    drv_valid  = 1'b0;
    drv_data   = 4'h0;
    drv_sready = 1'b1;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_out("reset A", 0, 0, 0, 0, 0, 0);
    sel = 1'b1;
    #1;
    chk_out("reset B", 0, 0, 0, 0, 0, 0);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 4'h0, 1);
    chk_out("post-reset A", 0, 0, 0, 0, 1, 0);

    // ---------------- frame table ----------------
    for (int i = 0; i < 8; i++) begin
      sel = frames[i].sel;
      cyc(1, frames[i].word, 1);
      chk_out($sformatf("frame%0d idle", i), 0, 0, 0, 0, 1, 0);
      for (int b = 0; b < 4; b++) begin
        cyc(0, 4'h0, 1);
        chk_out($sformatf("frame%0d bit%0d", i, b), 1, frames[i].exp_bits[3-b],
                (b == 0), (b == 3), ((b == 3) && !frames[i].sel), 1);
      end
      if (frames[i].sel) begin
        for (int g = 0; g < 2; g++) begin
          cyc(0, 4'h0, 1);
          chk_out($sformatf("frame%0d gap%0d", i, g), 0, 0, 0, 0, 0, 1);
        end
      end
      cyc(0, 4'h0, 1);
      chk_out($sformatf("frame%0d done", i), 0, 0, 0, 0, 1, 0);
    end

    // ---------------- back-to-back with ignored in_data (A) ----------------
    begin
      logic [7:0] exp_stream;
      logic [3:0] dseq [8];
      exp_stream = 8'b1010_0101;
      dseq = '{4'h3, 4'hC, 4'h6, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0};
      sel = 1'b0;
      cyc(1, 4'hA, 1);
      chk_out("b2b idle", 0, 0, 0, 0, 1, 0);
      for (int c = 0; c < 8; c++) begin
        cyc((c < 4), dseq[c], 1);
        chk_out($sformatf("b2b bit%0d", c), 1, exp_stream[7-c],
                ((c % 4) == 0), ((c % 4) == 3), ((c % 4) == 3), 1);
      end
      cyc(0, 4'h0, 1);
      chk_out("b2b done", 0, 0, 0, 0, 1, 0);
    end

    // ---------------- stall sequence (A) ----------------
    sel = 1'b0;
    for (int i = 0; i < 16; i++) run_steps($sformatf("stall step%0d", i), stall_seq[i]);

    // ---------------- gap sequence (B) ----------------
    sel = 1'b1;
    for (int i = 0; i < 15; i++) run_steps($sformatf("gap step%0d", i), gap_seq[i]);

    // ---------------- reset mid-frame (A) ----------------
    sel = 1'b0;
    cyc(1, 4'hF, 1);
    chk_out("rst-mid idle", 0, 0, 0, 0, 1, 0);
    cyc(0, 4'h0, 1);
    chk_out("rst-mid bit0", 1, 1, 1, 0, 0, 1);
    cyc(0, 4'h0, 1);
    chk_out("rst-mid bit1", 1, 1, 0, 0, 0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst-mid asserted", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'h0, 1);
      chk_out($sformatf("rst-mid after%0d", i), 0, 0, 0, 0, 1, 0);
    end
    cyc(1, 4'h9, 1);
    chk_out("rst-mid new idle", 0, 0, 0, 0, 1, 0);
    begin
      logic [3:0] exp_new;
      exp_new = 4'b1001;
      for (int b = 0; b < 4; b++) begin
        cyc(0, 4'h0, 1);
        chk_out($sformatf("rst-mid new bit%0d", b), 1, exp_new[3-b], (b == 0), (b == 3), (b == 3), 1);
      end
    end
    cyc(0, 4'h0, 1);
    chk_out("rst-mid new done", 0, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
